// File: rtl/alu_sequencer.sv
// Sequencer around a combinational arithmetic_unit: runs ADC/SBC/CMP/PASS requests and owns status register P.
// Optional decimal adjust step is enabled by defining DECIMAL_MODE_EN.
module alu_sequencer #(
    parameter logic [7:0] P_RESET = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       flag_wr,
    input  logic [7:0] flag_wdata,
    output logic [7:0] p_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_flags_in,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags,
    input  logic [7:0] alu_flags_ena
);

    localparam logic [1:0] OP_ADC  = 2'b00;
    localparam logic [1:0] OP_SBC  = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DADJ = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state_reg;
    logic [7:0] p_reg;
    logic [1:0] op_reg;
    logic       dec_reg;

    // P as seen by an accept: a coincident flag write takes effect for this op
    logic [7:0] p_eff;
    logic       cin_next;
    logic       dec_next;
    logic [7:0] commit_mask;
    logic [7:0] dadj_res;
    logic       dadj_c;

    assign alu_opcode = 2'b00;
    assign p_out      = p_reg | 8'h20;
    assign p_eff      = flag_wr ? flag_wdata : p_reg;
    assign cin_next   = (req_op == OP_CMP) ? 1'b1 : p_eff[0];

`ifdef DECIMAL_MODE_EN
    assign dec_next = p_eff[3] & ~req_op[1];
`else
    assign dec_next = 1'b0;
`endif

    always_comb begin
        commit_mask = 8'h00;
        case (op_reg)
            OP_ADC, OP_SBC: commit_mask = alu_flags_ena;
            OP_CMP:         commit_mask = alu_flags_ena & 8'h83;
            default:        commit_mask = 8'h00;
        endcase
    end

`ifdef DECIMAL_MODE_EN
    // Binary result sits in rsp_data and binary carry in p_reg[0] when DADJ runs
    logic [4:0] lo_sum;
    logic       half;
    logic [7:0] adj_lo;
    always_comb begin
        lo_sum   = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0000, alu_flags_in[0]};
        half     = lo_sum[4];
        adj_lo   = rsp_data;
        dadj_res = rsp_data;
        dadj_c   = p_reg[0];
        if (op_reg == OP_ADC) begin
            if ((rsp_data[3:0] > 4'd9) || half)
                adj_lo = rsp_data + 8'h06;
            dadj_res = adj_lo;
            if ((adj_lo[7:4] > 4'd9) || p_reg[0]) begin
                dadj_res = adj_lo + 8'h60;
                dadj_c   = 1'b1;
            end
        end else begin
            if (!half)
                adj_lo = rsp_data - 8'h06;
            dadj_res = p_reg[0] ? adj_lo : adj_lo - 8'h60;
        end
    end
`else
    assign dadj_res = rsp_data;
    assign dadj_c   = p_reg[0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            p_reg        <= P_RESET;
            op_reg       <= OP_ADC;
            dec_reg      <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_flags_in <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flag_wr)
                        p_reg <= flag_wdata;
                    if (req_valid) begin
                        op_reg       <= req_op;
                        alu_a        <= req_a;
                        alu_b        <= (req_op == OP_ADC) ? req_b : ~req_b;
                        alu_flags_in <= {7'b0000000, cin_next};
                        dec_reg      <= dec_next;
                        req_ready    <= 1'b0;
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    p_reg    <= (p_reg & ~commit_mask) | (alu_flags & commit_mask);
                    rsp_data <= (op_reg == OP_PASS) ? alu_a : alu_result;
                    if (dec_reg) begin
                        state_reg <= DADJ;
                    end else begin
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end
                end
                DADJ: begin
                    rsp_data  <= dadj_res;
                    p_reg[0]  <= dadj_c;
                    rsp_valid <= 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops against a behavioural 6502-style model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       flag_wr;
    logic [7:0] flag_wdata;
    logic [7:0] p_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_flags_in;
    logic [7:0] alu_result;
    logic [7:0] alu_flags;
    logic [7:0] alu_flags_ena;

    int checks = 0;
    int errors = 0;
    logic [7:0] mp;
    logic [7:0] got;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .flag_wr(flag_wr), .flag_wdata(flag_wdata), .p_out(p_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_flags_ena(alu_flags_ena)
    );

    // Stand-in for the combinational arithmetic_unit in ADC mode: N V - - - - Z C
    logic [8:0] alu_sum;
    assign alu_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_flags_in[0]};
    assign alu_result    = alu_sum[7:0];
    assign alu_flags     = {alu_sum[7], (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]),
                            4'b0000, alu_sum[7:0] == 8'h00, alu_sum[8]};
    assign alu_flags_ena = 8'hC3;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Reference: 6502 arithmetic expressed as signed integer math on the operands
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, output logic [7:0] r, output logic [7:0] np,
                         output bit dec);
        int ai, bi, ci, d, lo;
        ai = a; bi = b; ci = p[0] ? 1 : 0;
        np = p; dec = 0; r = a;
        case (op)
            2'd0: begin
                d = ai + bi + ci;
                r = d[7:0];
                np[0] = d > 255;
                np[6] = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'd1: begin
                d = ai - bi - (1 - ci);
                r = d[7:0];
                np[0] = d >= 0;
                np[6] = (a[7] != b[7]) && (r[7] != a[7]);
            end
            2'd2: begin
                d = ai - bi;
                r = d[7:0];
                np[0] = d >= 0;
            end
            default: r = a;
        endcase
        if (op != 2'd3) begin
            np[1] = (r == 8'h00);
            np[7] = r[7];
        end
`ifdef DECIMAL_MODE_EN
        if (p[3] && op < 2'd2) begin
            dec = 1;
            if (op == 2'd0) begin
                lo = (ai % 16) + (bi % 16) + ci;
                if ((r % 16) > 9 || lo > 15) r = r + 8'h06;
                if ((r / 16) > 9 || np[0]) begin
                    r = r + 8'h60;
                    np[0] = 1'b1;
                end
            end else begin
                lo = (ai % 16) - (bi % 16) - (1 - ci);
                if (lo < 0) r = r - 8'h06;
                if (!np[0]) r = r - 8'h60;
            end
        end
`endif
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit fw, input logic [7:0] fwd, input int hold,
                          output logic [7:0] obs);
        logic [7:0] pin, er, ep;
        bit dec;
        @(negedge clk);
        check("req_ready_idle", {7'd0, req_ready}, 8'd1);
        pin = fw ? fwd : mp;
        model(op, a, b, pin, er, ep, dec);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        flag_wr = fw; flag_wdata = fwd;
        @(negedge clk);
        req_valid = 1'b0;
        flag_wr = 1'b1; flag_wdata = 8'($urandom);
        check("busy_ready", {7'd0, req_ready}, 8'd0);
        check("lat_early", {7'd0, rsp_valid}, 8'd0);
        if (dec) begin
            @(negedge clk);
            flag_wdata = 8'($urandom);
            check("lat_dadj", {7'd0, rsp_valid}, 8'd0);
        end
        @(negedge clk);
        check("lat_valid", {7'd0, rsp_valid}, 8'd1);
        for (int i = 0; i < hold; i++) begin
            flag_wdata = 8'($urandom);
            @(negedge clk);
            check("hold_valid", {7'd0, rsp_valid}, 8'd1);
            check("hold_data", rsp_data, er);
            check("hold_ready", {7'd0, req_ready}, 8'd0);
        end
        check("rsp_data", rsp_data, er);
        check("p_out", p_out, ep | 8'h20);
        obs = rsp_data;
        flag_wr = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", {7'd0, rsp_valid}, 8'd0);
        check("ready_back", {7'd0, req_ready}, 8'd1);
        mp = ep;
        $display("txn op=%0d a=%02h b=%02h fw=%0d rsp=%02h p=%02h hold=%0d", op, a, b, fw, obs, p_out, hold);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = 8'h00; req_b = 8'h00;
        flag_wr = 1'b0; flag_wdata = 8'h00; rsp_ready = 1'b0;
        mp = 8'h20;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_p", p_out, 8'h20);
        check("rst_req_ready", {7'd0, req_ready}, 8'd1);
        check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_fin", alu_flags_in, 8'h00);
        check("alu_opcode", {6'd0, alu_opcode}, 8'h00);

        run_op(2'd0, 8'h50, 8'h50, 1'b0, 8'h00, 0, got);
        check("adc_50_50", got, 8'hA0);
        check("adc_50_50_p", p_out, 8'hE0);

        run_op(2'd1, 8'h00, 8'h01, 1'b1, 8'h01, 0, got);
        check("sbc_00_01", got, 8'hFF);
        check("sbc_00_01_p", p_out, 8'hA0);

        run_op(2'd2, 8'h40, 8'h40, 1'b1, 8'h40, 5, got);
        check("cmp_40_40", got, 8'h00);
        check("cmp_40_40_p", p_out, 8'h63);

        run_op(2'd3, 8'h5A, 8'hC3, 1'b0, 8'h00, 1, got);
        check("pass_a", got, 8'h5A);

        // Flag write while idle loads P directly
        @(negedge clk);
        flag_wr = 1'b1; flag_wdata = 8'h81;
        @(negedge clk);
        flag_wr = 1'b0;
        check("idle_flag_wr", p_out, 8'hA1);
        mp = 8'h81;

        // Reset during EXEC abandons the op
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_a = 8'h12; req_b = 8'h34;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_p", p_out, 8'h20);
        check("midrst_ready", {7'd0, req_ready}, 8'd1);
        check("midrst_valid", {7'd0, rsp_valid}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        mp = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {7'd0, rsp_valid}, 8'd0);
        end

`ifdef DECIMAL_MODE_EN
        run_op(2'd0, 8'h19, 8'h28, 1'b1, 8'h08, 0, got);
        check("bcd_19_28", got, 8'h47);
        check("bcd_19_28_c", {7'd0, p_out[0]}, 8'd0);
        run_op(2'd0, 8'h99, 8'h01, 1'b1, 8'h08, 0, got);
        check("bcd_99_01", got, 8'h00);
        check("bcd_99_01_c", {7'd0, p_out[0]}, 8'd1);
`endif

        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
                   8'($urandom), int'($urandom_range(0, 3)), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
